// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: rotates an active-low column strobe, debounces whole
// scan frames and keeps a four-key history that can feed a 4-digit display.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 6250,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        gclock,
  input  logic        greset,
  input  logic [3:0]  RowIn,
  output logic [3:0]  ColOut,
  output logic [3:0]  keyCode,
  output logic        keyValid,
  output logic        keyHeld,
  output logic [15:0] dataOut
);

  localparam int CW = (SCAN_DIV < 1) ? 1 : $clog2(SCAN_DIV + 1);
  localparam logic [CW-1:0] SCAN_TC = CW'(SCAN_DIV);
  localparam logic [3:0] DB_TARGET = (DEBOUNCE_SCANS < 1)  ? 4'd1  :
                                     (DEBOUNCE_SCANS > 15) ? 4'd15 : 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_e;

  logic [CW-1:0] divCnt_q, divCnt_d;
  logic [1:0]    colIdx_q, colIdx_d;
  logic [3:0]    rowMeta_q, rowSync_q;
  logic          accFound_q, accFound_d;
  logic [3:0]    accCode_q, accCode_d;
  state_e        state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    dbCnt_q, dbCnt_d;
  logic [3:0]    keyCode_q, keyCode_d;
  logic          keyValid_q, keyValid_d;
  logic          keyHeld_q, keyHeld_d;
  logic [15:0]   data_q, data_d;

  logic          tick;
  logic          frameEnd;
  logic          colHit;
  logic [1:0]    rowIdx;
  logic [3:0]    colCode;
  logic          frameFound;
  logic [3:0]    frameCode;
  logic [3:0]    dbCntInc;
  logic          accept;
  logic          releaseDone;

  assign tick     = (divCnt_q == SCAN_TC);
  assign frameEnd = tick && (colIdx_q == 2'd3);
  assign ColOut   = ~(4'b0001 << colIdx_q);

  always_comb begin
    divCnt_d = tick ? '0 : divCnt_q + CW'(1);
    colIdx_d = tick ? colIdx_q + 2'd1 : colIdx_q;
  end

  // Lowest row wins within the column currently being sampled.
  always_comb begin
    colHit = (rowSync_q != 4'hF);
    rowIdx = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!rowSync_q[r]) rowIdx = 2'(r);
    end
    colCode = {rowIdx, colIdx_q};
  end

  // The earliest column with a closed key owns the frame; later hits are ignored.
  assign frameFound = accFound_q | colHit;
  assign frameCode  = accFound_q ? accCode_q : colCode;

  always_comb begin
    accFound_d = accFound_q;
    accCode_d  = accCode_q;
    if (frameEnd) begin
      accFound_d = 1'b0;
      accCode_d  = 4'd0;
    end else if (tick && !accFound_q && colHit) begin
      accFound_d = 1'b1;
      accCode_d  = colCode;
    end
  end

  assign dbCntInc = (dbCnt_q >= DB_TARGET) ? DB_TARGET : dbCnt_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    dbCnt_d     = dbCnt_q;
    accept      = 1'b0;
    releaseDone = 1'b0;
    if (frameEnd) begin
      case (state_q)
        IDLE: begin
          if (frameFound) begin
            cand_d = frameCode;
            if (DB_TARGET == 4'd1) begin
              state_d = PRESSED;
              dbCnt_d = 4'd0;
              accept  = 1'b1;
            end else begin
              state_d = DEBOUNCE;
              dbCnt_d = 4'd1;
            end
          end
        end
        DEBOUNCE: begin
          if (!frameFound) begin
            state_d = IDLE;
            dbCnt_d = 4'd0;
          end else if (frameCode == cand_q) begin
            dbCnt_d = dbCntInc;
            if (dbCntInc >= DB_TARGET) begin
              state_d = PRESSED;
              dbCnt_d = 4'd0;
              accept  = 1'b1;
            end
          end else begin
            cand_d  = frameCode;
            dbCnt_d = 4'd1;
          end
        end
        PRESSED: begin
          if (!frameFound) begin
            if (DB_TARGET == 4'd1) begin
              state_d     = IDLE;
              dbCnt_d     = 4'd0;
              releaseDone = 1'b1;
            end else begin
              state_d = RELEASE;
              dbCnt_d = 4'd1;
            end
          end
        end
        RELEASE: begin
          if (frameFound) begin
            state_d = PRESSED;
            dbCnt_d = 4'd0;
          end else begin
            dbCnt_d = dbCntInc;
            if (dbCntInc >= DB_TARGET) begin
              state_d     = IDLE;
              dbCnt_d     = 4'd0;
              releaseDone = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          dbCnt_d = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    keyCode_d  = keyCode_q;
    keyValid_d = accept;
    keyHeld_d  = keyHeld_q;
    data_d     = data_q;
    if (accept) begin
      keyCode_d = frameCode;
      keyHeld_d = 1'b1;
      data_d    = {data_q[11:0], frameCode};
    end else if (releaseDone) begin
      keyHeld_d = 1'b0;
    end
  end

  always_ff @(posedge gclock or posedge greset) begin
    if (greset) begin
      divCnt_q   <= '0;
      colIdx_q   <= 2'd0;
      rowMeta_q  <= 4'hF;
      rowSync_q  <= 4'hF;
      accFound_q <= 1'b0;
      accCode_q  <= 4'd0;
      state_q    <= IDLE;
      cand_q     <= 4'd0;
      dbCnt_q    <= 4'd0;
      keyCode_q  <= 4'd0;
      keyValid_q <= 1'b0;
      keyHeld_q  <= 1'b0;
      data_q     <= 16'd0;
    end else begin
      divCnt_q   <= divCnt_d;
      colIdx_q   <= colIdx_d;
      rowMeta_q  <= RowIn;
      rowSync_q  <= rowMeta_q;
      accFound_q <= accFound_d;
      accCode_q  <= accCode_d;
      state_q    <= state_d;
      cand_q     <= cand_d;
      dbCnt_q    <= dbCnt_d;
      keyCode_q  <= keyCode_d;
      keyValid_q <= keyValid_d;
      keyHeld_q  <= keyHeld_d;
      data_q     <= data_d;
    end
  end

  assign keyCode  = keyCode_q;
  assign keyValid = keyValid_q;
  assign keyHeld  = keyHeld_q;
  assign dataOut  = data_q;

endmodule
